// File: rtl/regs_arb_pkg.sv
// Shared sizes and requester encoding for the register-file write-port arbiter.
package regs_arb_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_MD = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
  import regs_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wb_i,
  input  logic req_md_i,
  output logic gnt_wb_o,
  output logic gnt_md_o,
  output req_e last_grant_o
);

  req_e last_grant_q;
  req_e last_grant_d;

  // Grant selection from current requests and the last winner
  always_comb begin
    gnt_wb_o = 1'b0;
    gnt_md_o = 1'b0;
    if (req_wb_i && req_md_i) begin
      if (last_grant_q == REQ_MD) begin
        gnt_wb_o = 1'b1;
      end else begin
        gnt_md_o = 1'b1;
      end
    end else if (req_wb_i) begin
      gnt_wb_o = 1'b1;
    end else if (req_md_i) begin
      gnt_md_o = 1'b1;
    end else begin
      gnt_wb_o = 1'b0;
      gnt_md_o = 1'b0;
    end
  end

  // Next last-grant value
  always_comb begin
    if (gnt_wb_o) begin
      last_grant_d = REQ_WB;
    end else if (gnt_md_o) begin
      last_grant_d = REQ_MD;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Reset favours WB on the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_MD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter (WB vs MD) with MD busy scoreboard and read hazards.
// Optional write-stage bypass to decode is enabled by defining REGS_ARB_BYPASS_EN.
module regs_wb_arbiter
  import regs_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  output logic            wb_ready,
  input  logic            md_valid,
  input  logic [AW-1:0]   md_addr,
  input  logic [DW-1:0]   md_data,
  output logic            md_ready,
  input  logic            md_issue,
  input  logic [AW-1:0]   md_issue_addr,
  output logic            issue_stall,
  input  logic [AW-1:0]   R_addr_A,
  input  logic [AW-1:0]   R_addr_B,
  output logic            hazard_A,
  output logic            hazard_B,
  output logic            byp_A_hit,
  output logic            byp_B_hit,
  output logic [DW-1:0]   byp_data_A,
  output logic [DW-1:0]   byp_data_B,
  output logic            L_S,
  output logic [AW-1:0]   Wt_addr,
  output logic [DW-1:0]   wt_data,
  output logic [NREG-1:0] busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

  logic [NREG-1:0] busy_q, busy_d;
  logic            ls_q, ls_d;
  logic [AW-1:0]   wt_addr_q, wt_addr_d;
  logic [DW-1:0]   wt_data_q, wt_data_d;
  logic            wb_elig, md_elig;
  logic            gnt_wb, gnt_md;
  req_e            last_grant;
  logic            match_a, match_b;

  // WB may not overtake an outstanding MD result to the same register
  assign wb_elig = !rst && wb_valid && !(busy_q[wb_addr] && (wb_addr != ZERO_ADDR));
  assign md_elig = !rst && md_valid;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_wb_i     (wb_elig),
    .req_md_i     (md_elig),
    .gnt_wb_o     (gnt_wb),
    .gnt_md_o     (gnt_md),
    .last_grant_o (last_grant)
  );

  assign wb_ready    = gnt_wb;
  assign md_ready    = gnt_md;
  assign issue_stall = md_issue && (md_issue_addr != ZERO_ADDR) && busy_q[md_issue_addr];

  // Write-stage load from the granted requester
  always_comb begin
    ls_d      = 1'b0;
    wt_addr_d = wt_addr_q;
    wt_data_d = wt_data_q;
    if (gnt_wb) begin
      ls_d      = (wb_addr != ZERO_ADDR);
      wt_addr_d = wb_addr;
      wt_data_d = wb_data;
    end else if (gnt_md) begin
      ls_d      = (md_addr != ZERO_ADDR);
      wt_addr_d = md_addr;
      wt_data_d = md_data;
    end else begin
      ls_d = 1'b0;
    end
  end

  // Scoreboard: MD result clears, accepted MD issue sets
  always_comb begin
    busy_d = busy_q;
    if (gnt_md && (md_addr != ZERO_ADDR)) begin
      busy_d[md_addr] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (md_issue && !issue_stall && (md_issue_addr != ZERO_ADDR)) begin
      busy_d[md_issue_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Write stage and scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= {NREG{1'b0}};
      ls_q      <= 1'b0;
      wt_addr_q <= ZERO_ADDR;
      wt_data_q <= {DW{1'b0}};
    end else begin
      busy_q    <= busy_d;
      ls_q      <= ls_d;
      wt_addr_q <= wt_addr_d;
      wt_data_q <= wt_data_d;
    end
  end

  assign match_a = ls_q && (wt_addr_q == R_addr_A);
  assign match_b = ls_q && (wt_addr_q == R_addr_B);

`ifdef REGS_ARB_BYPASS_EN
  // The write stage forwards its data instead of stalling decode
  assign hazard_A   = (R_addr_A != ZERO_ADDR) && busy_q[R_addr_A];
  assign hazard_B   = (R_addr_B != ZERO_ADDR) && busy_q[R_addr_B];
  assign byp_A_hit  = (R_addr_A != ZERO_ADDR) && match_a;
  assign byp_B_hit  = (R_addr_B != ZERO_ADDR) && match_b;
  assign byp_data_A = byp_A_hit ? wt_data_q : {DW{1'b0}};
  assign byp_data_B = byp_B_hit ? wt_data_q : {DW{1'b0}};
`else
  assign hazard_A   = (R_addr_A != ZERO_ADDR) && (busy_q[R_addr_A] || match_a);
  assign hazard_B   = (R_addr_B != ZERO_ADDR) && (busy_q[R_addr_B] || match_b);
  assign byp_A_hit  = 1'b0;
  assign byp_B_hit  = 1'b0;
  assign byp_data_A = {DW{1'b0}};
  assign byp_data_B = {DW{1'b0}};
`endif

  assign L_S      = ls_q;
  assign Wt_addr  = wt_addr_q;
  assign wt_data  = wt_data_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed self-checking bench for regs_wb_arbiter; expectations follow REGS_ARB_BYPASS_EN.
module tb_regs_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, md_valid, md_issue;
  logic [4:0]  wb_addr, md_addr, md_issue_addr, R_addr_A, R_addr_B;
  logic [31:0] wb_data, md_data;
  logic        wb_ready, md_ready, issue_stall;
  logic        hazard_A, hazard_B, byp_A_hit, byp_B_hit, L_S;
  logic [31:0] byp_data_A, byp_data_B, wt_data, busy_vec;
  logic [4:0]  Wt_addr;
  logic [31:0] rf [32] = '{default: 32'h0};
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  regs_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr), .issue_stall(issue_stall),
    .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .hazard_A(hazard_A), .hazard_B(hazard_B),
    .byp_A_hit(byp_A_hit), .byp_B_hit(byp_B_hit),
    .byp_data_A(byp_data_A), .byp_data_B(byp_data_B),
    .L_S(L_S), .Wt_addr(Wt_addr), .wt_data(wt_data), .busy_vec(busy_vec)
  );

  // Architectural register file fed by the write stage
  always @(posedge clk) begin
    if (L_S) rf[Wt_addr] <= wt_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; md_valid = 1'b0; md_issue = 1'b0;
    wb_addr = 5'd0; md_addr = 5'd0; md_issue_addr = 5'd0;
    wb_data = 32'h0; md_data = 32'h0; R_addr_A = 5'd0; R_addr_B = 5'd0;

    // reset with a request present: nothing granted or written
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h5;
    tick(); tick(); #1;
    check_eq("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    check_eq("rst_busy", busy_vec, 32'h0);
    check_eq("rst_ls", {31'd0, L_S}, 32'd0);
    check_eq("rst_waddr", {27'd0, Wt_addr}, 32'd0);
    check_eq("rst_wdata", wt_data, 32'h0);
    wb_valid = 1'b0; rst = 1'b0;
    tick();

    // conflict: WB wins first, MD next cycle
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h22;
    #1;
    check_eq("cf_wb_ready", {31'd0, wb_ready}, 32'd1);
    check_eq("cf_md_ready0", {31'd0, md_ready}, 32'd0);
    tick(); wb_valid = 1'b0; #1;
    check_eq("cf_ls1", {31'd0, L_S}, 32'd1);
    check_eq("cf_waddr1", {27'd0, Wt_addr}, 32'd3);
    check_eq("cf_wdata1", wt_data, 32'h11);
    check_eq("cf_md_ready1", {31'd0, md_ready}, 32'd1);
    tick(); md_valid = 1'b0; #1;
    check_eq("cf_waddr2", {27'd0, Wt_addr}, 32'd4);
    check_eq("cf_wdata2", wt_data, 32'h22);
    tick();
    check_eq("cf_ls_idle", {31'd0, L_S}, 32'd0);
    check_eq("cf_r3", rf[3], 32'h11);
    check_eq("cf_r4", rf[4], 32'h22);

    // busy set/clear, issue stall, r0 issue
    R_addr_A = 5'd5; md_issue = 1'b1; md_issue_addr = 5'd5; #1;
    check_eq("bs_stall0", {31'd0, issue_stall}, 32'd0);
    check_eq("bs_haz_pre", {31'd0, hazard_A}, 32'd0);
    tick(); md_issue = 1'b0; #1;
    check_eq("bs_busy5", busy_vec, 32'h20);
    check_eq("bs_haz1", {31'd0, hazard_A}, 32'd1);
    tick();
    check_eq("bs_haz2", {31'd0, hazard_A}, 32'd1);
    md_issue = 1'b1; #1;
    check_eq("bs_stall2", {31'd0, issue_stall}, 32'd1);
    tick(); md_issue_addr = 5'd0; #1;
    check_eq("bs_stall_r0", {31'd0, issue_stall}, 32'd0);
    check_eq("bs_busy_held", busy_vec, 32'h20);
    tick(); md_issue = 1'b0; #1;
    check_eq("bs_busy_r0", busy_vec, 32'h20);
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'h55; #1;
    check_eq("bs_md_ready", {31'd0, md_ready}, 32'd1);
    check_eq("bs_haz_grant", {31'd0, hazard_A}, 32'd1);
    tick(); md_valid = 1'b0; #1;
    check_eq("bs_busy_clr", busy_vec, 32'h0);
    check_eq("bs_waddr", {27'd0, Wt_addr}, 32'd5);
`ifdef REGS_ARB_BYPASS_EN
    check_eq("bs_haz_ws", {31'd0, hazard_A}, 32'd0);
    check_eq("bs_byp_hit", {31'd0, byp_A_hit}, 32'd1);
    check_eq("bs_byp_data", byp_data_A, 32'h55);
`else
    check_eq("bs_haz_ws", {31'd0, hazard_A}, 32'd1);
    check_eq("bs_byp_hit", {31'd0, byp_A_hit}, 32'd0);
`endif
    tick();
    check_eq("bs_haz_done", {31'd0, hazard_A}, 32'd0);
    R_addr_A = 5'd0;

    // WAW block on r7
    md_issue = 1'b1; md_issue_addr = 5'd7;
    tick(); md_issue = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77; #1;
    check_eq("waw_blk1", {31'd0, wb_ready}, 32'd0);
    tick();
    check_eq("waw_blk2", {31'd0, wb_ready}, 32'd0);
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h70; #1;
    check_eq("waw_md_ready", {31'd0, md_ready}, 32'd1);
    check_eq("waw_blk3", {31'd0, wb_ready}, 32'd0);
    tick(); md_valid = 1'b0; #1;
    check_eq("waw_wb_ready", {31'd0, wb_ready}, 32'd1);
    check_eq("waw_md_data", wt_data, 32'h70);
    tick(); wb_valid = 1'b0; #1;
    check_eq("waw_wb_data", wt_data, 32'h77);
    tick();
    check_eq("waw_r7", rf[7], 32'h77);

    // WB write to r0 accepted and dropped
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD; #1;
    check_eq("r0_ready", {31'd0, wb_ready}, 32'd1);
    tick(); wb_valid = 1'b0; #1;
    check_eq("r0_ls", {31'd0, L_S}, 32'd0);
    check_eq("r0_busy", busy_vec, 32'h0);

    // bypass / write-stage hazard on r6
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'hABCD;
    R_addr_A = 5'd6; R_addr_B = 5'd3;
    tick(); wb_valid = 1'b0; #1;
    check_eq("byp_ls", {31'd0, L_S}, 32'd1);
`ifdef REGS_ARB_BYPASS_EN
    check_eq("byp_hazA", {31'd0, hazard_A}, 32'd0);
    check_eq("byp_hitA", {31'd0, byp_A_hit}, 32'd1);
    check_eq("byp_dataA", byp_data_A, 32'hABCD);
`else
    check_eq("byp_hazA", {31'd0, hazard_A}, 32'd1);
    check_eq("byp_hitA", {31'd0, byp_A_hit}, 32'd0);
`endif
    check_eq("byp_hazB", {31'd0, hazard_B}, 32'd0);
    check_eq("byp_hitB", {31'd0, byp_B_hit}, 32'd0);
    tick(); R_addr_A = 5'd0;

    // reset mid-operation
    md_issue = 1'b1; md_issue_addr = 5'd2;
    tick(); md_issue_addr = 5'd9;
    tick(); md_issue = 1'b0; R_addr_B = 5'd9; #1;
    check_eq("rm_busy", busy_vec, 32'h204);
    check_eq("rm_hazB", {31'd0, hazard_B}, 32'd1);
    md_valid = 1'b1; md_addr = 5'd2; md_data = 32'h2222;
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
    rst = 1'b1; #1;
    check_eq("rm_md_ready", {31'd0, md_ready}, 32'd0);
    check_eq("rm_wb_ready", {31'd0, wb_ready}, 32'd0);
    tick(); rst = 1'b0; md_valid = 1'b0; wb_valid = 1'b0; #1;
    check_eq("rm_busy_clr", busy_vec, 32'h0);
    check_eq("rm_ls", {31'd0, L_S}, 32'd0);
    check_eq("rm_hazB_clr", {31'd0, hazard_B}, 32'd0);
    tick();
    check_eq("rm_r1", rf[1], 32'h0);
    check_eq("rm_r2", rf[2], 32'h0);
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hA;
    md_valid = 1'b1; md_addr = 5'd11; md_data = 32'hB; #1;
    check_eq("rm_cf_wb", {31'd0, wb_ready}, 32'd1);
    check_eq("rm_cf_md", {31'd0, md_ready}, 32'd0);
    tick(); wb_valid = 1'b0; #1;
    check_eq("rm_cf_md2", {31'd0, md_ready}, 32'd1);
    tick(); md_valid = 1'b0;
    tick();
    check_eq("rm_r10", rf[10], 32'hA);
    check_eq("rm_r11", rf[11], 32'hB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
